// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: pipelined shift/rotate unit, one stage per amount bit, with valid/ready handshakes
module barrel_shifter_pipe #(
  parameter int N = 8,
  parameter int TAG_W = 4,
  localparam int SW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic [SW-1:0]    in_amt,
  input  logic [2:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);
  logic [N-1:0]     d  [0:SW];
  logic [N-1:0]     sh [0:SW-1];
  logic [SW-1:0]    a  [0:SW-1];
  logic [2:0]       m  [0:SW];
  logic [TAG_W-1:0] t  [0:SW];
  logic [SW:0]      v;
  logic             adv;

  function automatic logic [N-1:0] step(input logic [N-1:0] w, input logic [2:0] md, input int s);
    logic [N-1:0] asr;
    asr = $signed(w) >>> s;
    return md == 3'd0 ? w << s :
           md == 3'd1 ? w >> s :
           md == 3'd2 ? asr :
           md == 3'd3 ? (w << s) | (w >> (N - s)) :
           md == 3'd4 ? (w >> s) | (w << (N - s)) : w;
  endfunction

  // Register k holds the word with amount bits 0..k-1 applied; register SW is the output.
  for (genvar k = 0; k < SW; k++) begin : g_st
    assign sh[k] = a[k][k] ? step(d[k], m[k], 1 << k) : d[k];
  end

  assign adv       = ~v[SW] | out_ready;
  assign in_ready  = adv;
  assign out_valid = v[SW];
  assign out_data  = d[SW];
  assign out_tag   = t[SW];
  assign out_err   = m[SW] > 3'd4;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      for (int i = 0; i <= SW; i++) begin
        d[i] <= '0;
        m[i] <= '0;
        t[i] <= '0;
      end
      for (int i = 0; i < SW; i++) a[i] <= '0;
    end else if (adv) begin
      v    <= {v[SW-1:0], in_valid};
      d[0] <= in_data;
      a[0] <= in_amt;
      m[0] <= in_mode;
      t[0] <= in_tag;
      for (int i = 0; i < SW; i++) begin
        d[i+1] <= sh[i];
        m[i+1] <= m[i];
        t[i+1] <= t[i];
      end
      for (int i = 1; i < SW; i++) a[i] <= a[i-1];
    end
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb_barrel_shifter_pipe: directed vectors, expected results queued at acceptance and checked by a monitor
module tb_barrel_shifter_pipe;
  logic       clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic       in_ready, out_valid, out_err;
  logic [7:0] in_data = 0, out_data;
  logic [2:0] in_amt = 0, in_mode = 0;
  logic [3:0] in_tag = 0, out_tag;

  typedef struct {logic [7:0] d; logic [3:0] t; logic e; int acc; bit lat;} exp_t;
  typedef struct {logic [7:0] d; logic [2:0] a; logic [2:0] m; logic [7:0] e; bit err;} vec_t;

  exp_t q[$];
  int cyc = 0, n_vec = 0, n_bad = 0;

  barrel_shifter_pipe #(.N(8), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic       hold = 0, he = 0;
  logic [7:0] hd = 0;
  logic [3:0] ht = 0;

  always @(negedge clk) begin
    if (hold && rst_n) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, hd);
      chk("hold_tag", out_tag, ht);
      chk("hold_err", out_err, he);
    end
    if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
    if (out_valid && out_ready) begin
      exp_t e;
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_result: got tag %0h data %0h expected none", out_tag, out_data);
      end else begin
        e = q.pop_front();
        chk("data", out_data, e.d);
        chk("tag", out_tag, e.t);
        chk("err", out_err, e.e);
        if (e.lat) chk("latency", cyc - e.acc, 3);
      end
    end
    hold = rst_n && out_valid && !out_ready;
    hd = out_data;
    ht = out_tag;
    he = out_err;
  end

  task automatic send(input logic [7:0] d, input logic [2:0] a, input logic [2:0] md, input logic [3:0] tg,
                      input logic [7:0] ed, input bit ee, input bit lat, output int w);
    w = 0;
    in_valid = 1;
    in_data = d;
    in_amt = a;
    in_mode = md;
    in_tag = tg;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 50 cycles");
    end else q.push_back('{ed, tg, ee, cyc + 1, lat});
    @(posedge clk);
    #2 in_valid = 0;
  endtask

  task automatic drain;
    int w = 0;
    while ((q.size() != 0 || out_valid) && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  vec_t vt[18] = '{
    '{8'h81, 3'd1, 3'd0, 8'h02, 1'b0}, '{8'h90, 3'd3, 3'd1, 8'h12, 1'b0},
    '{8'h90, 3'd3, 3'd2, 8'hF2, 1'b0}, '{8'h81, 3'd4, 3'd3, 8'h18, 1'b0},
    '{8'h81, 3'd1, 3'd4, 8'hC0, 1'b0}, '{8'hA5, 3'd0, 3'd0, 8'hA5, 1'b0},
    '{8'hA5, 3'd0, 3'd1, 8'hA5, 1'b0}, '{8'hA5, 3'd0, 3'd2, 8'hA5, 1'b0},
    '{8'hA5, 3'd0, 3'd3, 8'hA5, 1'b0}, '{8'hA5, 3'd0, 3'd4, 8'hA5, 1'b0},
    '{8'hB4, 3'd3, 3'd3, 8'hA5, 1'b0}, '{8'hB4, 3'd6, 3'd4, 8'hD2, 1'b0},
    '{8'h80, 3'd7, 3'd2, 8'hFF, 1'b0}, '{8'h7F, 3'd7, 3'd2, 8'h00, 1'b0},
    '{8'hFF, 3'd7, 3'd1, 8'h01, 1'b0}, '{8'h3C, 3'd2, 3'd5, 8'h3C, 1'b1},
    '{8'h55, 3'd1, 3'd0, 8'hAA, 1'b0}, '{8'h5A, 3'd7, 3'd7, 8'h5A, 1'b1}
  };
  logic [7:0] s_lsl[8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [7:0] s_ror[8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  initial begin
    int w;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_tag", out_tag, 0);
    chk("reset_out_err", out_err, 0);
    @(posedge clk);
    #2;
    for (int i = 0; i < 18; i++) begin
      send(vt[i].d, vt[i].a, vt[i].m, 4'(i), vt[i].e, vt[i].err, 1, w);
      drain();
      @(posedge clk);
      #2;
    end
    for (int i = 0; i < 8; i++) begin
      send(8'h01, 3'(i), 3'd0, 4'(i), s_lsl[i], 0, 1, w);
      chk("stream_in_ready_wait", w, 0);
    end
    drain();
    @(posedge clk);
    #2;
    fork
      begin
        repeat (3) @(posedge clk);
        #2 out_ready = 0;
        repeat (5) @(posedge clk);
        #2 out_ready = 1;
      end
      for (int i = 0; i < 8; i++) send(8'h80, 3'(i), 3'd4, 4'(i), s_ror[i], 0, 0, w);
    join
    drain();
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) send(8'h11, 3'd1, 3'd0, 4'(12 + i), 8'h22, 0, 0, w);
    rst_n = 0;
    #1 chk("async_reset_out_valid", out_valid, 0);
    q.delete();
    @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk("post_reset_in_ready", in_ready, 1);
    @(posedge clk);
    #2;
    send(8'h01, 3'd7, 3'd0, 4'd9, 8'h80, 0, 1, w);
    drain();
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/barrel_shifter_pipe.md
Name: barrel_shifter_pipe

Overview:
- Parametrised, pipelined successor to the team's combinational barrel shifter.
- Supports five shift/rotate modes and an arbitrary power-of-two data width.
- Uses one register stage per shift-amount bit, with valid/ready handshakes on input and output.
- Sits between an upstream producer and a downstream consumer in the datapath; carries an opaque tag alongside each operand.

Parameters:
- N, 8, data width in bits; must be a power of two, N >= 2.
- TAG_W, 4, width of the sideband tag carried with each operand; must be >= 1.
- SW, $clog2(N), shift-amount width and pipeline depth L; derived, not to be overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand present on in_* this cycle.
- in_ready  out  1  block accepts operand this cycle.
- in_data  in  N  operand.
- in_amt  in  SW  shift amount, 0..N-1.
- in_mode  in  3  operation: 000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR, 101-111 illegal.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result present on out_*.
- out_ready  in  1  consumer accepts result this cycle.
- out_data  out  N  result.
- out_tag  out  TAG_W  tag of this result.
- out_err  out  1  operand used an illegal mode.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, out_valid, out_data, out_tag, out_err and internal data/amt/mode/tag registers go to 0 immediately.
  - Operands in flight are discarded.
  - in_ready is 1 in the first cycle after reset release.
- Pipeline: stages 0..SW-1, one register per stage.
  - Stage k applies a displacement of 2^k when amt bit k is 1, and passes the word through when amt bit k is 0.
  - amt, mode, tag and err travel with the data.
- Latency: L = SW cycles. An operand accepted at edge t appears on out_* after edge t+L when there is no stall (N=8 gives L=3).
- Throughput: one operand per cycle when out_ready is held high.
- Advance enable: adv = ~out_valid | out_ready; in_ready = adv.
  - All stages shift together when adv = 1 and hold their contents when adv = 0. This is a global stall, not bubble-collapsing.
- Acceptance: an operand is accepted on an edge where in_valid & in_ready. If in_valid = 0 while adv = 1, a bubble (valid = 0) enters stage 0.
- Output hold: while out_valid & ~out_ready, out_data, out_tag and out_err must remain stable.
- Mode semantics (final result, amt = a):
  - LSL: in_data << a, zero fill.
  - LSR: in_data >> a, zero fill.
  - ASR: >> a, filled with in_data[N-1].
  - ROL: rotate left by a.
  - ROR: rotate right by a.
- a = 0: result equals in_data in every mode.
- Illegal mode (101-111): out_data = in_data unchanged, out_err = 1. out_err is 0 for all legal modes.
- Width rules: all arithmetic is confined to N bits; bits shifted out are discarded, and no carry output is produced.
- Simultaneous events:
  - Output handshake and input acceptance on the same edge are both honoured (full-throughput case).
  - in_valid while in_ready = 0: the operand is not accepted, and the producer must hold it stable.
- Ordering: results leave in acceptance order, and each result carries its own tag.

Test Plan:
- N=8; LSL 0x81 a=1, LSR 0x90 a=3, ASR 0x90 a=3 -> out_data 0x02, 0x12, 0xF2 respectively. Each result arrives 3 cycles after acceptance with out_err = 0.
- ROL 0x81 a=4 -> 0x18; ROR 0x81 a=1 -> 0xC0; any mode with a=0 on 0xA5 -> 0xA5.
- Stream 8 back-to-back operands with tags 0..7 and out_ready = 1 -> 8 consecutive out_valid cycles, tags in order 0..7, in_ready constantly 1.
- Same stream with out_ready low for 5 cycles mid-stream -> in_ready low during the stall, out_* stable, no loss or duplication, order preserved.
- Mode 101 on 0x3C a=2 -> out_data 0x3C, out_err = 1; the following legal operand returns out_err = 0.
- Assert rst_n low with 3 operands in flight -> out_valid drops to 0 immediately. After release, no stale results appear, and a new operand (LSL 0x01 a=7 -> 0x80) completes in 3 cycles.
